// File: rtl/series_ctrl.sv
// -----------------------------------------------------------------------------
// series_ctrl
//
// Sequencer for the iterative term/accumulate datapath. A run clears the
// iteration counter and accumulator, loads the operand, then performs eight
// multiply/accumulate iterations. Each iteration launches the shared
// multiplier and waits for it: on the mul_done pulse when MUL_LAT = 0, or for
// exactly MUL_LAT cycles when MUL_LAT = 1..15. A run ends when the counter
// reports carryout.
//
// Handshake semantics: mul_start is a single-cycle launch with no
// back-pressure. mul_done is a result-valid pulse that is only accepted in
// MWAIT with MUL_LAT = 0; at any other time it has no effect. start is a
// level request sampled in IDLE and must drop before a new run can begin, so
// a held start yields exactly one run.
//
// Ports
//   clk        : clock, all state on the rising edge
//   rst        : asynchronous active-low reset (0 = reset), forces IDLE
//   start      : run request, level-sampled in IDLE
//   abort      : synchronous abandon of the current run (ignored in IDLE)
//   carryout   : registered carry from the iteration counter
//   mul_done   : multiplier result valid
//   initcnt    : clear the iteration counter
//   encnt      : advance the iteration counter
//   ldx        : load the operand register
//   clracc     : clear the accumulator
//   mul_start  : one-cycle multiplier launch
//   ldterm     : latch the multiplier product as the new term
//   ldacc      : accumulate the term
//   ready      : controller is in IDLE
//   done       : run complete
//   dbg_state  : current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module series_ctrl #(
  parameter int unsigned MUL_LAT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       carryout,
  input  logic       mul_done,
  output logic       initcnt,
  output logic       encnt,
  output logic       ldx,
  output logic       clracc,
  output logic       mul_start,
  output logic       ldterm,
  output logic       ldacc,
  output logic       ready,
  output logic       done,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_MUL   = 3'd2,
    S_MWAIT = 3'd3,
    S_ACC   = 3'd4,
    S_CHECK = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Wait-counter value on the last MWAIT cycle in fixed-latency mode.
  localparam logic [3:0] LAT_LAST = 4'(MUL_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       mul_ready;

  // State register and wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Multiplier result is available in the current MWAIT cycle.
  always_comb begin
    if (MUL_LAT == 0) mul_ready = mul_done;
    else              mul_ready = (wait_q == LAT_LAST);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_INIT;
      S_INIT:  state_d = S_MUL;
      S_MUL: begin
        state_d = S_MWAIT;
        wait_d  = 4'd0;
      end
      S_MWAIT: begin
        wait_d = wait_q + 4'd1;
        if (mul_ready) state_d = S_ACC;
      end
      S_ACC:   state_d = S_CHECK;
      // carryout already reflects the encnt issued in ACC.
      S_CHECK: state_d = carryout ? S_DONE : S_MUL;
      S_DONE:  if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything except IDLE, where start keeps priority.
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // Moore output decode: strobes depend on the state register only.
  always_comb begin
    initcnt   = 1'b0;
    encnt     = 1'b0;
    ldx       = 1'b0;
    clracc    = 1'b0;
    mul_start = 1'b0;
    ldterm    = 1'b0;
    ldacc     = 1'b0;
    ready     = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE:  ready = 1'b1;
      S_INIT: begin
        initcnt = 1'b1;
        clracc  = 1'b1;
        ldx     = 1'b1;
      end
      S_MUL:   mul_start = 1'b1;
      S_ACC: begin
        ldterm = 1'b1;
        ldacc  = 1'b1;
        encnt  = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_series_ctrl.sv
// -----------------------------------------------------------------------------
// tb_series_ctrl
//
// Two controller instances: one in handshake mode (MUL_LAT = 0) and one with a
// fixed multiplier latency of 2. Each has a behavioural iteration counter
// producing carryout. Expected run lengths come from the timing rule
// done cycle = 2 + 8 * (3 + W), with cycle 1 being the INIT cycle.
// -----------------------------------------------------------------------------
module tb_series_ctrl;

  localparam int LAT_F = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic start_f = 1'b0, abort_f = 1'b0, mul_done_f = 1'b0, carry_f = 1'b0;
  logic initcnt_f, encnt_f, ldx_f, clracc_f, mul_start_f, ldterm_f, ldacc_f, ready_f, done_f;
  logic [2:0] dbg_f;

  logic start_h = 1'b0, abort_h = 1'b0, mul_done_h = 1'b0, carry_h = 1'b0;
  logic initcnt_h, encnt_h, ldx_h, clracc_h, mul_start_h, ldterm_h, ldacc_h, ready_h, done_h;
  logic [2:0] dbg_h;

  int n_tests = 0;
  int n_fail  = 0;

  series_ctrl #(.MUL_LAT(LAT_F)) dut_f (
    .clk(clk), .rst(rst), .start(start_f), .abort(abort_f), .carryout(carry_f),
    .mul_done(mul_done_f), .initcnt(initcnt_f), .encnt(encnt_f), .ldx(ldx_f),
    .clracc(clracc_f), .mul_start(mul_start_f), .ldterm(ldterm_f), .ldacc(ldacc_f),
    .ready(ready_f), .done(done_f), .dbg_state(dbg_f)
  );

  series_ctrl #(.MUL_LAT(0)) dut_h (
    .clk(clk), .rst(rst), .start(start_h), .abort(abort_h), .carryout(carry_h),
    .mul_done(mul_done_h), .initcnt(initcnt_h), .encnt(encnt_h), .ldx(ldx_h),
    .clracc(clracc_h), .mul_start(mul_start_h), .ldterm(ldterm_h), .ldacc(ldacc_h),
    .ready(ready_h), .done(done_h), .dbg_state(dbg_h)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural iteration counters ----------------
  int cnt_f = 0, cnt_h = 0;
  always @(posedge clk) begin
    if (initcnt_f) begin cnt_f <= 0; carry_f <= 1'b0; end
    else if (encnt_f) begin cnt_f <= cnt_f + 1; carry_f <= (cnt_f + 1 >= 8); end
    if (initcnt_h) begin cnt_h <= 0; carry_h <= 1'b0; end
    else if (encnt_h) begin cnt_h <= cnt_h + 1; carry_h <= (cnt_h + 1 >= 8); end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({ready_f, ready_h} !== 2'b11) begin
      n_fail++; $display("FAIL reset_ready: got %b required 11", {ready_f, ready_h});
    end
    n_tests++;
    if ({initcnt_f, encnt_f, ldx_f, clracc_f, mul_start_f, ldterm_f, ldacc_f, done_f,
         initcnt_h, encnt_h, ldx_h, clracc_h, mul_start_h, ldterm_h, ldacc_h, done_h} !== 16'h0) begin
      n_fail++; $display("FAIL reset_strobes: strobes not all 0 during reset");
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if ({ready_f, ready_h, initcnt_f, encnt_f, ldx_f, clracc_f, mul_start_f, ldterm_f, ldacc_f, done_f,
           initcnt_h, encnt_h, ldx_h, clracc_h, mul_start_h, ldterm_h, ldacc_h, done_h} !== 18'h30000) begin
        n_fail++; $display("FAIL idle_cycle%0d: ready=%b%b strobes not quiet", i, ready_f, ready_h);
      end
    end
  endtask

  // One fixed-latency run on dut_f with a one-cycle start pulse; mul_done is
  // randomised throughout and must have no effect.
  task automatic test_fixed(input string tag);
    int k, n_init, n_ms, n_en, n_la, n_lt, n_ldx, n_clr, bad_coin, done_cyc, ready_cyc, exp_done;
    exp_done = 2 + 8 * (3 + LAT_F);
    n_init = 0; n_ms = 0; n_en = 0; n_la = 0; n_lt = 0; n_ldx = 0; n_clr = 0; bad_coin = 0;
    done_cyc = -1; ready_cyc = -1;
    @(negedge clk); start_f = 1'b1;
    @(negedge clk); start_f = 1'b0;
    k = 1;
    while (k <= 200 && ready_cyc < 0) begin
      n_init += int'(initcnt_f); n_ms += int'(mul_start_f); n_en += int'(encnt_f);
      n_la += int'(ldacc_f); n_lt += int'(ldterm_f); n_ldx += int'(ldx_f); n_clr += int'(clracc_f);
      if (ldacc_f !== encnt_f || ldterm_f !== encnt_f) bad_coin++;
      if (done_f === 1'b1 && done_cyc < 0) done_cyc = k;
      if (ready_f === 1'b1 && done_cyc > 0) ready_cyc = k;
      mul_done_f = 1'($urandom_range(0, 1));
      @(negedge clk); k++;
    end
    mul_done_f = 1'b0;
    n_tests++; if (n_init !== 1) begin n_fail++; $display("FAIL %s_initcnt: got %0d required 1", tag, n_init); end
    n_tests++; if (n_ldx !== 1 || n_clr !== 1) begin n_fail++; $display("FAIL %s_ldx_clracc: got %0d/%0d required 1/1", tag, n_ldx, n_clr); end
    n_tests++; if (n_ms !== 8) begin n_fail++; $display("FAIL %s_mul_start: got %0d required 8", tag, n_ms); end
    n_tests++; if (n_en !== 8) begin n_fail++; $display("FAIL %s_encnt: got %0d required 8", tag, n_en); end
    n_tests++; if (n_la !== 8 || n_lt !== 8) begin n_fail++; $display("FAIL %s_ldacc_ldterm: got %0d/%0d required 8/8", tag, n_la, n_lt); end
    n_tests++; if (bad_coin !== 0) begin n_fail++; $display("FAIL %s_coincide: %0d cycles with ldterm/ldacc/encnt apart, required 0", tag, bad_coin); end
    n_tests++; if (done_cyc !== exp_done) begin n_fail++; $display("FAIL %s_done_cycle: got %0d required %0d", tag, done_cyc, exp_done); end
    n_tests++; if (ready_cyc !== exp_done + 1) begin n_fail++; $display("FAIL %s_ready_back: got %0d required %0d", tag, ready_cyc, exp_done + 1); end
  endtask

  // One handshake-mode run on dut_h; d[i] is the mul_done delay after the
  // i-th mul_start. With spur set, mul_done is also raised during each ACC.
  task automatic run_hs(input string tag, input int d[8], input bit spur);
    int k, idx, cd, md_cyc, n_init, n_ms, n_en, done_cyc, exp_done;
    exp_done = 2 + 8 * 3;
    for (int i = 0; i < 8; i++) exp_done += d[i];
    idx = 0; cd = 0; md_cyc = -10; n_init = 0; n_ms = 0; n_en = 0; done_cyc = -1;
    @(negedge clk); start_h = 1'b1;
    @(negedge clk); start_h = 1'b0;
    n_tests++;
    if (initcnt_h !== 1'b1) begin n_fail++; $display("FAIL %s_first_initcnt: got %b required 1", tag, initcnt_h); end
    k = 1;
    while (k <= 400 && done_cyc < 0) begin
      n_init += int'(initcnt_h); n_ms += int'(mul_start_h); n_en += int'(encnt_h);
      if (done_h === 1'b1) done_cyc = k;
      mul_done_h = 1'b0;
      if (mul_start_h === 1'b1) begin
        cd = (idx < 8) ? d[idx] : 1;
        idx++;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin mul_done_h = 1'b1; md_cyc = k; end
      end
      if (ldacc_h === 1'b1) begin
        n_tests++;
        if (k !== md_cyc + 1) begin n_fail++; $display("FAIL %s_acc_after_done: ACC at %0d required %0d", tag, k, md_cyc + 1); end
        if (spur) mul_done_h = 1'b1;
      end
      @(negedge clk); k++;
    end
    mul_done_h = 1'b0;
    n_tests++; if (n_init !== 1) begin n_fail++; $display("FAIL %s_initcnt: got %0d required 1", tag, n_init); end
    n_tests++; if (n_ms !== 8 || n_en !== 8) begin n_fail++; $display("FAIL %s_iterations: mul_start=%0d encnt=%0d required 8/8", tag, n_ms, n_en); end
    n_tests++; if (done_cyc !== exp_done) begin n_fail++; $display("FAIL %s_done_cycle: got %0d required %0d", tag, done_cyc, exp_done); end
    @(negedge clk);
    n_tests++; if (ready_h !== 1'b1) begin n_fail++; $display("FAIL %s_ready_back: got %b required 1", tag, ready_h); end
  endtask

  task automatic test_handshake();
    // Spurious mul_done in IDLE must not trigger anything.
    mul_done_h = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if ({ready_h, initcnt_h, mul_start_h, encnt_h, ldacc_h, ldterm_h, done_h} !== 7'b1000000) begin
        n_fail++; $display("FAIL hs_idle_spurious: ready=%b strobes=%b required 1/000000", ready_h,
                           {initcnt_h, mul_start_h, encnt_h, ldacc_h, ldterm_h, done_h});
      end
    end
    mul_done_h = 1'b0;
    run_hs("hs", '{1, 3, 5, 1, 1, 1, 1, 1}, 1'b1);
  endtask

  task automatic test_random_handshake();
    int d[8];
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) d[i] = $urandom_range(1, 6);
      run_hs($sformatf("rand%0d", r), d, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_held_start();
    int k, n_init, done_cyc, bad;
    n_init = 0; done_cyc = -1; bad = 0;
    @(negedge clk); start_f = 1'b1;
    @(negedge clk);
    k = 1;
    while (k <= 200 && done_cyc < 0) begin
      n_init += int'(initcnt_f);
      if (done_f === 1'b1) done_cyc = k;
      else begin @(negedge clk); k++; end
    end
    n_tests++;
    if (done_cyc !== 2 + 8 * (3 + LAT_F)) begin n_fail++; $display("FAIL held_done_cycle: got %0d required %0d", done_cyc, 2 + 8 * (3 + LAT_F)); end
    for (int i = 0; i < 20; i++) begin
      if (done_f !== 1'b1 || initcnt_f !== 1'b0) bad++;
      n_init += int'(initcnt_f);
      @(negedge clk);
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL held_done_level: %0d of 20 cycles wrong, required 0", bad); end
    n_tests++; if (n_init !== 1) begin n_fail++; $display("FAIL held_single_init: got %0d required 1", n_init); end
    start_f = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ready_f !== 1'b1 || done_f !== 1'b0) begin n_fail++; $display("FAIL held_release: ready=%b done=%b required 1/0", ready_f, done_f); end
  endtask

  task automatic test_abort();
    int k, n_ms, seen_done;
    n_ms = 0; seen_done = 0;
    @(negedge clk); start_h = 1'b1;
    @(negedge clk); start_h = 1'b0;
    k = 1;
    // No mul_done is returned, so MWAIT holds until the abort.
    while (k <= 200 && abort_h == 1'b0) begin
      if (done_h === 1'b1) seen_done++;
      if (mul_start_h === 1'b1) begin
        n_ms++;
        @(negedge clk); k++;
        if (n_ms == 4) abort_h = 1'b1;
        else mul_done_h = 1'b1;
        @(negedge clk); k++;
        mul_done_h = 1'b0;
      end else begin
        @(negedge clk); k++;
      end
    end
    @(negedge clk);
    abort_h = 1'b0;
    n_tests++;
    if (ready_h !== 1'b1 || done_h !== 1'b0) begin n_fail++; $display("FAIL abort_to_idle: ready=%b done=%b required 1/0", ready_h, done_h); end
    n_tests++;
    if (seen_done !== 0) begin n_fail++; $display("FAIL abort_no_done: done seen %0d cycles required 0", seen_done); end
    // Full minimum-length run after the abort: must start with initcnt.
    run_hs("post_abort", '{1, 1, 1, 1, 1, 1, 1, 1}, 1'b0);
    // abort in IDLE is ignored, start wins; abort in INIT returns to IDLE.
    @(negedge clk); start_h = 1'b1; abort_h = 1'b1;
    @(negedge clk); start_h = 1'b0;
    n_tests++;
    if (initcnt_h !== 1'b1) begin n_fail++; $display("FAIL abort_idle_ignored: initcnt=%b required 1", initcnt_h); end
    @(negedge clk); abort_h = 1'b0;
    n_tests++;
    if (ready_h !== 1'b1 || mul_start_h !== 1'b0) begin n_fail++; $display("FAIL abort_priority: ready=%b mul_start=%b required 1/0", ready_h, mul_start_h); end
  endtask

  task automatic test_reset_mid();
    int k, n_la;
    n_la = 0;
    @(negedge clk); start_f = 1'b1;
    @(negedge clk); start_f = 1'b0;
    k = 1;
    while (k <= 200 && n_la < 3) begin
      if (ldacc_f === 1'b1) n_la++;
      if (n_la < 3) begin @(negedge clk); k++; end
    end
    n_tests++;
    if (ldacc_f !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach_acc: ldacc=%b required 1", ldacc_f); end
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if ({ready_f, initcnt_f, encnt_f, ldx_f, clracc_f, mul_start_f, ldterm_f, ldacc_f, done_f} !== 9'b100000000) begin
      n_fail++; $display("FAIL rstmid_async: ready=%b strobes=%b required 1/00000000", ready_f,
                         {initcnt_f, encnt_f, ldx_f, clracc_f, mul_start_f, ldterm_f, ldacc_f, done_f});
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ready_f !== 1'b1) begin n_fail++; $display("FAIL rstmid_release: ready=%b required 1", ready_f); end
  endtask

  initial begin
    test_reset();
    test_fixed("fixed");
    test_handshake();
    test_random_handshake();
    test_held_start();
    test_abort();
    test_reset_mid();
    test_fixed("back_to_back");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/series_ctrl.md
# series_ctrl

Control unit that sequences the iterative term/accumulate datapath built around the 8-step iteration counter (`initcnt`/`encnt` in, `carryout` out). On a start request it clears the counter and accumulator, loads the operand, then runs eight multiply/accumulate iterations. Each iteration waits for the shared multiplier, either by its `mul_done` handshake or by a fixed latency. It finishes when the counter reports `carryout`. It sits between the top-level start/done interface and the datapath load/enable strobes.

## Interface
- `MUL_LAT`, default 0: multiplier wait mode. 0 means wait for `mul_done`. 1..15 means a fixed wait of `MUL_LAT` cycles with `mul_done` ignored.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: asynchronous, active-low reset (0 = reset). Forces the IDLE state immediately.
- `start` input 1: run request, level-sampled in IDLE.
- `abort` input 1: synchronous abandon of the current run.
- `carryout` input 1: registered carry from the iteration counter. High after the 8th `encnt`.
- `mul_done` input 1: multiplier result valid, sampled only in MWAIT when `MUL_LAT`=0.
- `initcnt` output 1: clear the counter, resetting `cntr`=0, `carryout`=0, `powercnt`=1.
- `encnt` output 1: advance the counter.
- `ldx` output 1: load the operand register.
- `clracc` output 1: clear the accumulator.
- `mul_start` output 1: one-cycle multiplier launch.
- `ldterm` output 1: latch the multiplier product as the new term.
- `ldacc` output 1: accumulate the term.
- `ready` output 1: in IDLE.
- `done` output 1: run complete.

## Operation
- Moore FSM. All outputs decode from the state register only, and all strobes are single-cycle per state visit.
- States: IDLE, INIT, MUL, MWAIT, ACC, CHECK, DONE.
- IDLE:
  - Outputs: `ready`=1.
  - Transition: `start`=1 → INIT.
- INIT:
  - Outputs: `initcnt`=1, `clracc`=1, `ldx`=1.
  - Transition: → MUL.
- MUL:
  - Outputs: `mul_start`=1. Clears the internal wait counter.
  - Transition: → MWAIT.
- MWAIT, with no strobes:
  - `MUL_LAT`=0: stay until `mul_done`=1 → ACC.
  - `MUL_LAT`=L>0: a 4-bit wait counter increments each cycle. Exit → ACC when the counter equals L-1, so MWAIT lasts exactly L cycles.
- ACC:
  - Outputs: `ldterm`=1, `ldacc`=1, `encnt`=1.
  - Transition: → CHECK.
- CHECK:
  - Samples `carryout`. This is the value already updated by the ACC-cycle `encnt`.
  - Transition: 1 → DONE, 0 → MUL.
- DONE:
  - Outputs: `done`=1. Held while `start`=1.
  - Transition: `start`=0 → IDLE. A held `start` therefore never triggers a second run.
- `abort`=1 in any state other than IDLE → IDLE next edge. No `done` is asserted, and the counter is left as-is (the next INIT clears it). `abort` takes priority over every other transition. In IDLE, `abort` is ignored and `start` still wins.
- `mul_done` outside MWAIT, or when `MUL_LAT`>0, is ignored.
- `carryout` outside CHECK is ignored.

## Timing
- Reset (`rst`=0), effective asynchronously:
  - State IDLE, `ready`=1.
  - All other outputs 0.
  - Wait counter 0.
- Reset mid-run aborts with the same outputs. Release is synchronous to the next `clk` edge.
- Number `start` sampled high in IDLE as edge E0. Then:
  - INIT is the cycle after E0.
  - Each iteration takes MUL 1 + MWAIT W + ACC 1 + CHECK 1 cycles, where W = `MUL_LAT`, or the cycles to `mul_done` (≥1).
  - Exactly 8 iterations run, so exactly 8 `encnt` and 8 `mul_start` pulses.
- `done` first goes high 2 + 8·(3+W) cycles after E0. For `MUL_LAT`=2 that is cycle 42.
- `mul_done` arriving in the first MWAIT cycle gives W=1. The minimum run is 2+8·4 = 34 cycles to `done`.
- `ldterm`/`ldacc`/`encnt` coincide in one cycle. The datapath must capture the product and accumulate on that same edge.

## Test plan
- Reset and idle:
  - Stimulus: hold `rst`=0, then release with `start`=0.
  - Required: `ready`=1 and all strobes 0 for 10 cycles.
- Fixed latency:
  - Stimulus: `MUL_LAT`=2, pulse `start` for 1 cycle, model counter with `carryout` after the 8th `encnt`.
  - Required: `initcnt` once; 8 each of `mul_start`/`encnt`/`ldacc`; `done` at cycle 42 after E0; `ready` back after `start` low.
- Handshake mode:
  - Stimulus: `MUL_LAT`=0, with `mul_done` returned 1, 3, 5, 1, 1, 1, 1, 1 cycles after each `mul_start`.
  - Required: each ACC exactly 1 cycle after the corresponding `mul_done`; `done` at cycle 2+24+14 = 40.
  - Required: a spurious `mul_done` in IDLE/ACC produces no strobe.
- Held start:
  - Stimulus: keep `start`=1 through completion for 20 cycles, then drop it.
  - Required: `done` stays 1 for those 20 cycles, no second INIT, IDLE 1 cycle after `start` falls.
- Abort/reset mid-run:
  - Stimulus: assert `abort` in the 4th MWAIT.
  - Required: IDLE next cycle, `done` never asserted; a new `start` produces a full 8-iteration run beginning with `initcnt`.
  - Stimulus: repeat with `rst`=0 asynchronously mid-ACC.
  - Required: strobes drop to 0 immediately, with no clock edge.
